// File: rtl/spc7110_data_port.sv
// rtl/spc7110_data_port.sv - SPC7110 direct data-ROM port ($4810-$481A) with one-byte prefetch buffer
module spc7110_data_port #(
  parameter logic [23:0] DROM_BASE = 24'h100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_enable,
  input  logic [3:0]  reg_addr,
  input  logic        reg_rd_strobe,
  input  logic        reg_wr_strobe,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        rom_rd_req,
  output logic [23:0] rom_addr,
  input  logic        rom_rd_ack,
  input  logic [7:0]  rom_data,
  output logic        fetch_busy
);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t      state;
  logic        dirty;
  logic [23:0] ptr, nxt_ptr;
  logic [15:0] adjust, nxt_adjust;
  logic [15:0] step, nxt_step;
  logic [7:0]  mode, nxt_mode;
  logic [7:0]  data_buf;
  logic        refetch;
  logic [15:0] inc;
  logic [23:0] fetch_addr;

  wire rd = reg_enable & reg_rd_strobe;
  wire wr = reg_enable & reg_wr_strobe;

  function automatic logic [23:0] ext16(input logic [15:0] v, input logic sgn);
    return {(sgn ? {8{v[15]}} : 8'h00), v};
  endfunction

  // Next register values and the refetch event for this cycle's SNES access.
  always_comb begin
    nxt_ptr    = ptr;
    nxt_adjust = adjust;
    nxt_step   = step;
    nxt_mode   = mode;
    refetch    = 1'b0;
    inc        = mode[0] ? step : 16'd1;
    if (wr) begin
      case (reg_addr)
        4'h1: begin nxt_ptr[7:0]   = reg_din; refetch = 1'b1; end
        4'h2: begin nxt_ptr[15:8]  = reg_din; refetch = 1'b1; end
        4'h3: begin nxt_ptr[23:16] = reg_din; refetch = 1'b1; end
        4'h4: begin nxt_adjust[7:0] = reg_din; refetch = 1'b1; end
        4'h5: begin
          nxt_adjust[15:8] = reg_din;
          if (mode[6:5] == 2'b01) nxt_ptr = ptr + ext16(nxt_adjust, mode[3]);
          refetch = 1'b1;
        end
        4'h6: nxt_step[7:0]  = reg_din;
        4'h7: nxt_step[15:8] = reg_din;
        4'h8: begin nxt_mode = reg_din; refetch = 1'b1; end
        default: ;
      endcase
    end else if (rd) begin
      if (reg_addr == 4'h0) begin
        if (mode[4]) nxt_adjust = adjust + inc;
        else         nxt_ptr    = ptr + ext16(inc, mode[3]);
        refetch = 1'b1;
      end else if (reg_addr == 4'hA && mode[6:5] == 2'b10) begin
        nxt_ptr = ptr + ext16(adjust, mode[3]);
        refetch = 1'b1;
      end
    end
    fetch_addr = DROM_BASE + (nxt_mode[1] ? nxt_ptr + ext16(nxt_adjust, nxt_mode[3]) : nxt_ptr);
  end

  assign fetch_busy = (state == S_FETCH) | refetch;

  always_comb begin
    case (reg_addr)
      4'h0, 4'hA: reg_dout = data_buf;
      4'h1:       reg_dout = ptr[7:0];
      4'h2:       reg_dout = ptr[15:8];
      4'h3:       reg_dout = ptr[23:16];
      4'h4:       reg_dout = adjust[7:0];
      4'h5:       reg_dout = adjust[15:8];
      4'h6:       reg_dout = step[7:0];
      4'h7:       reg_dout = step[15:8];
      4'h8:       reg_dout = mode;
      default:    reg_dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dirty      <= 1'b0;
      ptr        <= '0;
      adjust     <= '0;
      step       <= '0;
      mode       <= '0;
      data_buf   <= '0;
      rom_rd_req <= 1'b0;
      rom_addr   <= '0;
    end else begin
      ptr    <= nxt_ptr;
      adjust <= nxt_adjust;
      step   <= nxt_step;
      mode   <= nxt_mode;
      case (state)
        S_IDLE: begin
          if (refetch) begin
            state      <= S_FETCH;
            rom_rd_req <= 1'b1;
            rom_addr   <= fetch_addr;
          end
        end
        S_FETCH: begin
          if (rom_rd_ack) begin
            // Stale data is dropped and the request reissued without a gap.
            if (dirty || refetch) begin
              rom_addr <= fetch_addr;
              dirty    <= 1'b0;
            end else begin
              data_buf   <= rom_data;
              rom_rd_req <= 1'b0;
              state      <= S_IDLE;
            end
          end else if (refetch) begin
            dirty <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spc7110_data_port.sv
// tb/tb_spc7110_data_port.sv - self-checking bench for spc7110_data_port
module tb_spc7110_data_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_enable = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic        reg_rd_strobe = 1'b0;
  logic        reg_wr_strobe = 1'b0;
  logic [7:0]  reg_din = 8'h00;
  logic [7:0]  reg_dout;
  logic        rom_rd_req;
  logic [23:0] rom_addr;
  logic        rom_rd_ack;
  logic [7:0]  rom_data;
  logic        fetch_busy;

  logic        a_ack = 1'b0, m_ack = 1'b0;
  logic [7:0]  a_data = 8'h00, m_data = 8'h00;
  logic        auto_ack = 1'b1;
  int          ack_delay = 2;
  int          tests = 0, fails = 0;

  assign rom_rd_ack = a_ack | m_ack;
  assign rom_data   = m_ack ? m_data : a_data;

  spc7110_data_port #(.DROM_BASE(24'h100000)) dut (
    .clk(clk), .rst_n(rst_n), .reg_enable(reg_enable), .reg_addr(reg_addr),
    .reg_rd_strobe(reg_rd_strobe), .reg_wr_strobe(reg_wr_strobe), .reg_din(reg_din),
    .reg_dout(reg_dout), .rom_rd_req(rom_rd_req), .rom_addr(rom_addr),
    .rom_rd_ack(rom_rd_ack), .rom_data(rom_data), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  // Arbiter model: answers any request after ack_delay cycles with the ROM image byte.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rom_rd_req && rst_n) begin
        repeat (ack_delay) @(negedge clk);
        a_data = mem_byte(rom_addr);
        a_ack  = 1'b1;
        @(negedge clk);
        a_ack  = 1'b0;
      end
    end
  end

  // Reference model of the programmer-visible state.
  logic [23:0] m_ptr;
  logic [15:0] m_adj, m_step;
  logic [7:0]  m_mode, m_buf;
  bit          m_pend;

  function automatic logic [23:0] m_ext(input logic [15:0] v);
    int unsigned x = v;
    if (m_mode[3] && v >= 16'h8000) x = x + 32'hFF0000;
    return x[23:0];
  endfunction

  function automatic logic [23:0] m_fetch_addr();
    int unsigned a = m_ptr;
    if (m_mode[1]) a = a + m_ext(m_adj);
    a = (a + 32'h100000) % 32'h1000000;
    return a[23:0];
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_adj = 0; m_step = 0; m_mode = 0; m_buf = 0; m_pend = 0;
  endtask

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    case (a)
      4'h1: begin m_ptr[7:0] = d;   m_pend = 1; end
      4'h2: begin m_ptr[15:8] = d;  m_pend = 1; end
      4'h3: begin m_ptr[23:16] = d; m_pend = 1; end
      4'h4: begin m_adj[7:0] = d;   m_pend = 1; end
      4'h5: begin
        m_adj[15:8] = d; m_pend = 1;
        if (m_mode[6:5] == 2'b01) m_ptr = m_ptr + m_ext(m_adj);
      end
      4'h6: m_step[7:0] = d;
      4'h7: m_step[15:8] = d;
      4'h8: begin m_mode = d; m_pend = 1; end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] m_read_val(input logic [3:0] a);
    case (a)
      4'h0, 4'hA: return m_buf;
      4'h1: return m_ptr[7:0];
      4'h2: return m_ptr[15:8];
      4'h3: return m_ptr[23:16];
      4'h4: return m_adj[7:0];
      4'h5: return m_adj[15:8];
      4'h6: return m_step[7:0];
      4'h7: return m_step[15:8];
      4'h8: return m_mode;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_read_effect(input logic [3:0] a);
    logic [15:0] inc;
    inc = m_mode[0] ? m_step : 16'd1;
    if (a == 4'h0) begin
      if (m_mode[4]) m_adj = m_adj + inc;
      else           m_ptr = m_ptr + m_ext(inc);
      m_pend = 1;
    end else if (a == 4'hA && m_mode[6:5] == 2'b10) begin
      m_ptr = m_ptr + m_ext(m_adj);
      m_pend = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_enable = 1; reg_addr = a; reg_din = d; reg_wr_strobe = 1;
    @(negedge clk);
    reg_wr_strobe = 0; reg_enable = 0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    reg_enable = 1; reg_addr = a; reg_rd_strobe = 1;
    #1 d = reg_dout;
    @(negedge clk);
    reg_rd_strobe = 0; reg_enable = 0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    reg_addr = a;
    #1 d = reg_dout;
  endtask

  task automatic get_ptr(output logic [23:0] p);
    logic [7:0] b;
    peek(4'h1, b); p[7:0] = b;
    peek(4'h2, b); p[15:8] = b;
    peek(4'h3, b); p[23:16] = b;
  endtask

  task automatic wr_ptr(input logic [23:0] p);
    wr(4'h1, p[7:0]); wr(4'h2, p[15:8]); wr(4'h3, p[23:16]);
  endtask

  task automatic settle();
    int n = 0;
    while ((fetch_busy || rom_rd_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("settle_timeout", (n >= 200), 0);
    if (m_pend) begin
      m_buf  = mem_byte(m_fetch_addr());
      m_pend = 0;
    end
  endtask

  task automatic mack(input logic [7:0] d);
    @(negedge clk);
    m_ack = 1; m_data = d;
    @(negedge clk);
    m_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
  } vec_t;

  initial begin
    logic [7:0]  d;
    logic [23:0] p;
    vec_t vecs[14];

    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Reset state
    peek(4'h0, d);
    check("rst_buf", d, 8'h00);
    check("rst_req", rom_rd_req, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_rom_addr", rom_addr, 24'h000000);
    get_ptr(p);
    check("rst_ptr", p, 24'h000000);

    // 1: basic fetch and +1 post-increment
    wr_ptr(24'h012345);
    settle();
    check("t1_addr", rom_addr, 24'h112345);
    rd(4'h0, d);
    check("t1_data", d, mem_byte(24'h112345));
    check("t1_req_next", rom_rd_req, 1);
    check("t1_addr_next", rom_addr, 24'h112346);
    settle();
    get_ptr(p);
    check("t1_ptr", p, 24'h012346);

    // 2: signed and unsigned step
    wr(4'h6, 8'hFE); wr(4'h7, 8'hFF); wr(4'h8, 8'h09);
    wr_ptr(24'h000010);
    settle();
    for (int i = 1; i <= 3; i++) begin
      rd(4'h0, d);
      settle();
      get_ptr(p);
      check("t2_signed_ptr", p, 24'h000010 - 24'(2 * i));
    end
    wr(4'h8, 8'h01);
    wr_ptr(24'h000010);
    settle();
    rd(4'h0, d);
    settle();
    get_ptr(p);
    check("t2_unsigned_ptr", p, 24'h01000E);

    // 3: adjust-offset fetch and increment applied to adjust
    wr(4'h8, 8'h02); wr(4'h4, 8'h10); wr(4'h5, 8'h00);
    wr_ptr(24'h000100);
    settle();
    check("t3_addr", rom_addr, 24'h100110);
    peek(4'h0, d);
    check("t3_buf", d, mem_byte(24'h100110));
    wr(4'h8, 8'h12);
    settle();
    rd(4'h0, d);
    settle();
    peek(4'h4, d);
    check("t3_adj_l", d, 8'h11);
    peek(4'h5, d);
    check("t3_adj_h", d, 8'h00);
    get_ptr(p);
    check("t3_ptr", p, 24'h000100);

    // 4: adjust-add on $4815 write and on $481A read
    wr(4'h8, 8'h20);
    wr_ptr(24'h000100);
    wr(4'h4, 8'h40); wr(4'h5, 8'h00);
    settle();
    get_ptr(p);
    check("t4_wr5_ptr", p, 24'h000140);
    wr(4'h8, 8'h40);
    settle();
    rd(4'hA, d);
    check("t4_rdA_data", d, mem_byte(24'h100140));
    settle();
    get_ptr(p);
    check("t4_rdA_ptr", p, 24'h000180);
    wr(4'h8, 8'h00);
    settle();
    rd(4'hA, d);
    check("t4_rdA0_data", d, mem_byte(24'h100180));
    settle();
    get_ptr(p);
    check("t4_rdA0_ptr", p, 24'h000180);

    // 5: write during outstanding fetch, and ack coincident with write
    auto_ack = 0;
    wr(4'h1, 8'h10);
    check("t5_req", rom_rd_req, 1);
    check("t5_addr1", rom_addr, 24'h100110);
    repeat (2) @(negedge clk);
    wr(4'h1, 8'h20);
    repeat (2) @(negedge clk);
    mack(8'hEE);
    check("t5_req_held", rom_rd_req, 1);
    check("t5_addr2", rom_addr, 24'h100120);
    peek(4'h0, d);
    check("t5_stale_buf", d, mem_byte(24'h100180));
    mack(8'h77);
    check("t5_req_done", rom_rd_req, 0);
    peek(4'h0, d);
    check("t5_buf", d, 8'h77);
    wr(4'h1, 8'h30);
    check("t5_addr3", rom_addr, 24'h100130);
    @(negedge clk);
    reg_enable = 1; reg_addr = 4'h1; reg_din = 8'h40; reg_wr_strobe = 1;
    m_ack = 1; m_data = 8'h99;
    @(negedge clk);
    reg_wr_strobe = 0; reg_enable = 0; m_ack = 0;
    check("t5_coinc_req", rom_rd_req, 1);
    check("t5_coinc_addr", rom_addr, 24'h100140);
    peek(4'h0, d);
    check("t5_coinc_buf", d, 8'h77);
    mack(8'h66);
    peek(4'h0, d);
    check("t5_final_buf", d, 8'h66);

    // 6: reset mid-fetch, late ack ignored
    wr(4'h1, 8'h50);
    check("t6_req_pre", rom_rd_req, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("t6_req_rst", rom_rd_req, 0);
    check("t6_busy_rst", fetch_busy, 0);
    for (int a = 0; a <= 8; a++) begin
      peek(4'(a), d);
      check("t6_reg_rst", d, 8'h00);
    end
    @(negedge clk);
    rst_n = 1;
    mack(8'hA5);
    peek(4'h0, d);
    check("t6_late_ack_buf", d, 8'h00);
    check("t6_late_ack_req", rom_rd_req, 0);
    check("t6_late_ack_busy", fetch_busy, 0);
    auto_ack = 1;
    m_reset();

    // Register readback table
    vecs[0]  = '{4'h1, 8'h11, 8'h11};
    vecs[1]  = '{4'h2, 8'h22, 8'h22};
    vecs[2]  = '{4'h3, 8'h33, 8'h33};
    vecs[3]  = '{4'h4, 8'h44, 8'h44};
    vecs[4]  = '{4'h5, 8'h55, 8'h55};
    vecs[5]  = '{4'h6, 8'h66, 8'h66};
    vecs[6]  = '{4'h7, 8'h77, 8'h77};
    vecs[7]  = '{4'h8, 8'h84, 8'h84};
    vecs[8]  = '{4'h9, 8'hAB, 8'h00};
    vecs[9]  = '{4'hB, 8'hCD, 8'h00};
    vecs[10] = '{4'hC, 8'h5A, 8'h00};
    vecs[11] = '{4'hD, 8'hA5, 8'h00};
    vecs[12] = '{4'hE, 8'h3C, 8'h00};
    vecs[13] = '{4'hF, 8'hC3, 8'h00};
    for (int i = 0; i < 14; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      settle();
      peek(vecs[i].addr, d);
      check("tbl_readback", d, vecs[i].rexp);
    end
    check("tbl_rom_addr", rom_addr, 24'h432211);
    peek(4'h0, d);
    check("tbl_buf", d, mem_byte(24'h432211));

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] a;
      logic [7:0] v;
      a = 4'($urandom_range(0, 15));
      v = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wr(a, v);
        m_write(a, v);
      end else begin
        if (a == 4'h0 || a == 4'hA) begin
          ack_delay = $urandom_range(1, 4);
          settle();
        end
        rd(a, d);
        check("rnd_read", d, m_read_val(a));
        m_read_effect(a);
      end
      if (i % 25 == 24) begin
        settle();
        peek(4'h0, d);
        check("rnd_buf", d, m_buf);
        get_ptr(p);
        check("rnd_ptr", p, m_ptr);
      end
    end
    settle();
    peek(4'h0, d);
    check("rnd_final_buf", d, m_buf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
